p4_router_egress_ps_mux: RTL

Merges the P4 router's per-link 8-bit egress AXIS streams toward the PS into one tagged stream for a single PS DMA channel. Arbitrates round-robin at packet granularity, never interleaves packets, and tags each beat with its source link on tid. Packets longer than MTU_BYTES are truncated, flagged on tuser and drained. Sits between the router's egress_to_ps links and the PS DMA receive path.

---
 rtl/p4_router_egress_ps_mux.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/p4_router_egress_ps_mux.sv
// Packet-granular round-robin merge of per-link 8-bit egress AXIS streams into one tid-tagged stream.
// Optional per-link packet/truncation counters are built when P4_EGR_MUX_STATS_EN is defined.
`timescale 1ns/1ps

module p4_router_egress_ps_mux #(
  parameter  int unsigned NUM_LINKS = 4,
  parameter  int unsigned MTU_BYTES = 2000,
  localparam int unsigned ID_WIDTH  = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
  input  logic                      clk,
  input  logic                      sresetn,
  input  logic [NUM_LINKS-1:0][7:0] egress_in_tdata_i,
  input  logic [NUM_LINKS-1:0]      egress_in_tvalid_i,
  input  logic [NUM_LINKS-1:0]      egress_in_tlast_i,
  output logic [NUM_LINKS-1:0]      egress_in_tready_o,
  output logic [7:0]                merged_out_tdata_o,
  output logic                      merged_out_tvalid_o,
  input  logic                      merged_out_tready_i,
  output logic                      merged_out_tlast_o,
  output logic [ID_WIDTH-1:0]       merged_out_tid_o,
  output logic                      merged_out_tuser_o
`ifdef P4_EGR_MUX_STATS_EN
  ,
  output logic [31:0]               pkt_count_o   [NUM_LINKS],
  output logic [15:0]               trunc_count_o [NUM_LINKS]
`endif
);

  localparam int unsigned CNT_W    = $clog2(MTU_BYTES + 1);
  localparam int unsigned LINKS_P2 = 1 << ID_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]          data;
    logic                last;
    logic                user;
    logic [ID_WIDTH-1:0] id;
  } beat_t;

  state_e              state_q;
  logic [ID_WIDTH-1:0] grant_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic                out_valid_q;
  beat_t               out_q;

  // Inputs widened to a power of two so the grant can index them directly
  logic [LINKS_P2-1:0][7:0] data_ext;
  logic [LINKS_P2-1:0]      vld_ext;
  logic [LINKS_P2-1:0]      last_ext;
  logic [LINKS_P2-1:0]      ready_ext;

  assign data_ext = (LINKS_P2 * 8)'(egress_in_tdata_i);
  assign vld_ext  = LINKS_P2'(egress_in_tvalid_i);
  assign last_ext = LINKS_P2'(egress_in_tlast_i);

  logic                load_en_c;
  logic                cur_valid_c;
  logic                cur_last_c;
  logic [7:0]          cur_data_c;
  logic                xfer_acc_c;
  logic                trunc_c;
  logic [ID_WIDTH-1:0] next_ptr_c;

  assign load_en_c   = !out_valid_q || merged_out_tready_i;
  assign cur_valid_c = vld_ext[grant_q];
  assign cur_last_c  = last_ext[grant_q];
  assign cur_data_c  = data_ext[grant_q];
  assign xfer_acc_c  = (state_q == XFER) && cur_valid_c && load_en_c;
  assign trunc_c     = xfer_acc_c && !cur_last_c && (byte_cnt_q == CNT_W'(MTU_BYTES - 1));
  assign next_ptr_c  = (grant_q == ID_WIDTH'(NUM_LINKS - 1)) ? '0 : grant_q + ID_WIDTH'(1);

  // Round-robin search from rr_ptr upward with wrap; descending loop lets the nearest hit win
  logic                arb_hit_c;
  logic [ID_WIDTH-1:0] arb_idx_c;
  logic [ID_WIDTH:0]   arb_sum;

  always_comb begin
    arb_hit_c = 1'b0;
    arb_idx_c = '0;
    arb_sum   = '0;
    for (int i = int'(NUM_LINKS) - 1; i >= 0; i--) begin
      arb_sum = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(i);
      if (arb_sum >= (ID_WIDTH + 1)'(NUM_LINKS)) begin
        arb_sum = arb_sum - (ID_WIDTH + 1)'(NUM_LINKS);
      end
      if (vld_ext[arb_sum[ID_WIDTH-1:0]]) begin
        arb_hit_c = 1'b1;
        arb_idx_c = arb_sum[ID_WIDTH-1:0];
      end
    end
  end

  // Only the granted link sees tready; DRAIN sinks unconditionally
  always_comb begin
    ready_ext = '0;
    if (sresetn) begin
      if (state_q == XFER) begin
        ready_ext[grant_q] = load_en_c;
      end else if (state_q == DRAIN) begin
        ready_ext[grant_q] = 1'b1;
      end
    end
  end

  assign egress_in_tready_o = ready_ext[NUM_LINKS-1:0];

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (load_en_c) begin
        out_valid_q <= xfer_acc_c;
      end
      if (xfer_acc_c) begin
        out_q.data <= cur_data_c;
        out_q.last <= cur_last_c || trunc_c;
        out_q.user <= trunc_c;
        out_q.id   <= grant_q;
      end
      case (state_q)
        IDLE: begin
          if (arb_hit_c) begin
            grant_q <= arb_idx_c;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (xfer_acc_c) begin
            if (cur_last_c) begin
              byte_cnt_q <= '0;
              rr_ptr_q   <= next_ptr_c;
              state_q    <= IDLE;
            end else begin
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
              if (trunc_c) begin
                state_q <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (cur_valid_c && cur_last_c) begin
            byte_cnt_q <= '0;
            rr_ptr_q   <= next_ptr_c;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign merged_out_tvalid_o = out_valid_q;
  assign merged_out_tdata_o  = out_q.data;
  assign merged_out_tlast_o  = out_q.last;
  assign merged_out_tuser_o  = out_q.user;
  assign merged_out_tid_o    = out_q.id;

`ifdef P4_EGR_MUX_STATS_EN
  // Saturating per-link counters, bumped when the packet's final output beat loads
  for (genvar k = 0; k < int'(NUM_LINKS); k++) begin : g_stats
    logic [31:0] pkt_q;
    logic [15:0] trunc_q;
    logic        hit_c;

    assign hit_c = xfer_acc_c && (grant_q == ID_WIDTH'(k));

    always_ff @(posedge clk) begin
      if (!sresetn) begin
        pkt_q   <= '0;
        trunc_q <= '0;
      end else if (hit_c) begin
        if ((cur_last_c || trunc_c) && (pkt_q != '1)) begin
          pkt_q <= pkt_q + 32'd1;
        end
        if (trunc_c && (trunc_q != '1)) begin
          trunc_q <= trunc_q + 16'd1;
        end
      end
    end

    assign pkt_count_o[k]   = pkt_q;
    assign trunc_count_o[k] = trunc_q;
  end
`endif

endmodule
